// File: rtl/generador_transacciones_rtc.sv
// -----------------------------------------------------------------------------
// generador_transacciones_rtc
//
// Generates multiplexed address/data bursts towards an RTC chip. Each byte has
// an address phase and a data phase. Each phase has three parts: setup
// (T_SETUP clocks), strobe low (T_PULSO clocks) and hold (T_HOLD clocks).
// The address auto-increments between bytes and wraps at 2^ANCHO_DATO.
//
// Request/completion protocol: inicio is a level request that is only looked
// at in IDLE. escritura, dir_base and longitud are captured together with it.
// ocupado stays high for the whole burst. listo pulses for exactly one clock
// when the block returns to IDLE. inicio seen while busy is ignored.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   inicio                start request (sampled in IDLE only)
//   escritura             1 = write burst, 0 = read burst
//   dir_base              first RTC register address
//   longitud              byte count (clamped to LONG_MAX, 0 = no bus activity)
//   abortar               finish the current byte, then stop
//   dato_escribir         write byte for the current indice
//   bus_dato_in           RTC bus read value
//   a_d, cs, wr, rd       RTC strobes, active low (a_d: 0 = address phase)
//   bus_dato_out, bus_oe  bus drive value and its tristate enable
//   indice                index of the current byte within the burst
//   dato_leido            last captured read byte
//   dato_valido           one-clock pulse when dato_leido is refreshed
//   ocupado, listo        burst in progress / one-clock completion pulse
//   estado_dbg            current FSM state, for debug and checkers
//
// Every output comes straight from a flop. The output values are decoded from
// the next state, so they line up with the state register on every clock.
// -----------------------------------------------------------------------------
module generador_transacciones_rtc #(
  parameter int ANCHO_DATO = 8,
  parameter int T_SETUP    = 1,
  parameter int T_PULSO    = 4,
  parameter int T_HOLD     = 1,
  parameter int LONG_MAX   = 16,
  localparam int ANCHO_LONG = $clog2(LONG_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inicio,
  input  logic                  escritura,
  input  logic [ANCHO_DATO-1:0] dir_base,
  input  logic [ANCHO_LONG-1:0] longitud,
  input  logic                  abortar,
  input  logic [ANCHO_DATO-1:0] dato_escribir,
  input  logic [ANCHO_DATO-1:0] bus_dato_in,
  output logic                  a_d,
  output logic                  cs,
  output logic                  wr,
  output logic                  rd,
  output logic [ANCHO_DATO-1:0] bus_dato_out,
  output logic                  bus_oe,
  output logic [ANCHO_LONG-1:0] indice,
  output logic [ANCHO_DATO-1:0] dato_leido,
  output logic                  dato_valido,
  output logic                  ocupado,
  output logic                  listo,
  output logic [2:0]            estado_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_SETUP = 3'd1,
    ADDR_PULSO = 3'd2,
    ADDR_HOLD  = 3'd3,
    DATA_SETUP = 3'd4,
    DATA_PULSO = 3'd5,
    DATA_HOLD  = 3'd6,
    FIN        = 3'd7
  } estado_t;

  // The phase counter is loaded with (duration - 1) when a phase is entered.
  // The phase ends on the clock where the counter reads zero.
  localparam logic [3:0] CNT_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] CNT_PULSO = 4'(T_PULSO - 1);
  localparam logic [3:0] CNT_HOLD  = 4'(T_HOLD - 1);

  localparam logic [ANCHO_LONG-1:0] LONG_LIM = ANCHO_LONG'(LONG_MAX);
  localparam logic [ANCHO_LONG:0]   LONG_UNO = (ANCHO_LONG + 1)'(1);

  // Control state
  estado_t               estado_q, estado_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ANCHO_DATO-1:0] dir_q, dir_d;
  logic [ANCHO_LONG-1:0] long_q, long_d;
  logic [ANCHO_LONG-1:0] indice_q, indice_d;
  logic [ANCHO_DATO-1:0] wdata_q, wdata_d;
  logic                  esc_q, esc_d;
  logic                  abort_q, abort_d;

  // Registered outputs
  logic                  a_d_q, a_d_d;
  logic                  cs_q, cs_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  oe_q, oe_d;
  logic [ANCHO_DATO-1:0] out_q, out_d;
  logic [ANCHO_DATO-1:0] dato_leido_q, dato_leido_d;
  logic                  dato_valido_q, dato_valido_d;
  logic                  ocupado_q, ocupado_d;
  logic                  listo_q, listo_d;

  // Helpers
  logic                  fin_fase;
  logic                  mas_bytes;
  logic [ANCHO_LONG-1:0] long_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d      = estado_q;
    dir_d         = dir_q;
    long_d        = long_q;
    indice_d      = indice_q;
    wdata_d       = wdata_q;
    esc_d         = esc_q;
    abort_d       = abort_q;
    dato_leido_d  = dato_leido_q;
    dato_valido_d = 1'b0;

    fin_fase  = (cnt_q == 4'd0);
    // Extra top bit so that indice+1 cannot overflow when longitud = LONG_MAX.
    mas_bytes = (({1'b0, indice_q} + LONG_UNO) < {1'b0, long_q});
    long_in   = (longitud > LONG_LIM) ? LONG_LIM : longitud;
    cnt_d     = fin_fase ? cnt_q : (cnt_q - 4'd1);

    unique case (estado_q)
      IDLE: begin
        abort_d = 1'b0;
        if (inicio) begin
          if (long_in != '0) begin
            estado_d = ADDR_SETUP;
            cnt_d    = CNT_SETUP;
            dir_d    = dir_base;
            long_d   = long_in;
            esc_d    = escritura;
            indice_d = '0;
          end else begin
            estado_d = FIN;
          end
        end
      end
      ADDR_SETUP: if (fin_fase) begin
        estado_d = ADDR_PULSO;
        cnt_d    = CNT_PULSO;
      end
      ADDR_PULSO: if (fin_fase) begin
        estado_d = ADDR_HOLD;
        cnt_d    = CNT_HOLD;
      end
      ADDR_HOLD: if (fin_fase) begin
        estado_d = DATA_SETUP;
        cnt_d    = CNT_SETUP;
        // Capture the write byte as the data phase starts, so the registered
        // bus drive already shows it in the first DATA_SETUP clock.
        wdata_d  = dato_escribir;
      end
      DATA_SETUP: if (fin_fase) begin
        estado_d = DATA_PULSO;
        cnt_d    = CNT_PULSO;
      end
      DATA_PULSO: if (fin_fase) begin
        estado_d = DATA_HOLD;
        cnt_d    = CNT_HOLD;
        // Sample at the end of the last strobe-low clock. The pulse is then
        // seen in the first DATA_HOLD clock.
        if (!esc_q) begin
          dato_leido_d  = bus_dato_in;
          dato_valido_d = 1'b1;
        end
      end
      DATA_HOLD: if (fin_fase) begin
        // An abort raised in this same clock still counts.
        if (mas_bytes && !(abort_q || abortar)) begin
          estado_d = ADDR_SETUP;
          cnt_d    = CNT_SETUP;
          dir_d    = dir_q + ANCHO_DATO'(1);
          indice_d = indice_q + ANCHO_LONG'(1);
        end else begin
          estado_d = FIN;
        end
      end
      FIN: begin
        estado_d = IDLE;
        abort_d  = 1'b0;
      end
      default: estado_d = IDLE;
    endcase

    if (abortar && (estado_q != IDLE) && (estado_q != FIN)) begin
      abort_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state (fed into the output flops)
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d_d     = 1'b1;
    cs_d      = 1'b1;
    wr_d      = 1'b1;
    rd_d      = 1'b1;
    oe_d      = 1'b0;
    out_d     = '0;
    ocupado_d = 1'b1;
    listo_d   = 1'b0;

    unique case (estado_d)
      IDLE: ocupado_d = 1'b0;
      ADDR_SETUP, ADDR_HOLD: begin
        a_d_d = 1'b0;
        oe_d  = 1'b1;
        out_d = dir_d;
      end
      ADDR_PULSO: begin
        a_d_d = 1'b0;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = dir_d;
      end
      DATA_SETUP, DATA_HOLD: begin
        oe_d  = esc_d;
        out_d = esc_d ? wdata_d : '0;
      end
      DATA_PULSO: begin
        cs_d  = 1'b0;
        wr_d  = !esc_d;
        rd_d  = esc_d;
        oe_d  = esc_d;
        out_d = esc_d ? wdata_d : '0;
      end
      FIN: begin
        ocupado_d = 1'b0;
        listo_d   = 1'b1;
      end
      default: ocupado_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= IDLE;
      cnt_q         <= 4'd0;
      dir_q         <= '0;
      long_q        <= '0;
      indice_q      <= '0;
      wdata_q       <= '0;
      esc_q         <= 1'b0;
      abort_q       <= 1'b0;
      a_d_q         <= 1'b1;
      cs_q          <= 1'b1;
      wr_q          <= 1'b1;
      rd_q          <= 1'b1;
      oe_q          <= 1'b0;
      out_q         <= '0;
      dato_leido_q  <= '0;
      dato_valido_q <= 1'b0;
      ocupado_q     <= 1'b0;
      listo_q       <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      long_q        <= long_d;
      indice_q      <= indice_d;
      wdata_q       <= wdata_d;
      esc_q         <= esc_d;
      abort_q       <= abort_d;
      a_d_q         <= a_d_d;
      cs_q          <= cs_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      oe_q          <= oe_d;
      out_q         <= out_d;
      dato_leido_q  <= dato_leido_d;
      dato_valido_q <= dato_valido_d;
      ocupado_q     <= ocupado_d;
      listo_q       <= listo_d;
    end
  end

  assign a_d          = a_d_q;
  assign cs           = cs_q;
  assign wr           = wr_q;
  assign rd           = rd_q;
  assign bus_oe       = oe_q;
  assign bus_dato_out = out_q;
  assign indice       = indice_q;
  assign dato_leido   = dato_leido_q;
  assign dato_valido  = dato_valido_q;
  assign ocupado      = ocupado_q;
  assign listo        = listo_q;
  assign estado_dbg   = estado_q;

endmodule

// File: tb/tb_generador_transacciones_rtc.sv
// -----------------------------------------------------------------------------
// tb_generador_transacciones_rtc
//
// Directed testbench. There are two instances:
// - u_dut uses the default timing: 1/4/1 clocks, so one byte takes 12 clocks.
// - u_dut_p1 uses T_PULSO=1, so one byte takes 6 clocks.
//
// Cycle numbering: cycle 0 is the clock in which inicio is first high. At the
// default timing, byte b occupies cycles 12b+1 .. 12b+12. The offsets inside a
// byte are:
//   1 = address setup, 2..5 = address strobe, 6 = address hold,
//   7 = data setup,    8..11 = data strobe,   12 = data hold.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_generador_transacciones_rtc;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       reset_n;
  logic       inicio;
  logic       escritura;
  logic [7:0] dir_base;
  logic [4:0] longitud;
  logic       abortar;
  logic [7:0] dato_escribir;
  logic [7:0] bus_dato_in;

  logic       a_d, cs, wr, rd, bus_oe, dato_valido, ocupado, listo;
  logic [7:0] bus_dato_out, dato_leido;
  logic [4:0] indice;
  logic [2:0] estado_dbg;

  logic       p_a_d, p_cs, p_wr, p_rd, p_bus_oe, p_dato_valido, p_ocupado, p_listo;
  logic [7:0] p_bus_dato_out, p_dato_leido;
  logic [4:0] p_indice;
  logic [2:0] p_estado_dbg;

  int checks = 0;
  int errors = 0;

  // Per-cycle capture.
  // sig = {a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido}
  logic [7:0] c_sig [0:255];
  logic [7:0] c_out [0:255];
  logic [7:0] c_dl  [0:255];
  logic [4:0] c_idx [0:255];
  logic [7:0] p_sig [0:255];
  logic [7:0] p_out [0:255];
  logic [7:0] p_dl  [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generador_transacciones_rtc u_dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .escritura(escritura),
    .dir_base(dir_base), .longitud(longitud), .abortar(abortar),
    .dato_escribir(dato_escribir), .bus_dato_in(bus_dato_in),
    .a_d(a_d), .cs(cs), .wr(wr), .rd(rd), .bus_dato_out(bus_dato_out),
    .bus_oe(bus_oe), .indice(indice), .dato_leido(dato_leido),
    .dato_valido(dato_valido), .ocupado(ocupado), .listo(listo),
    .estado_dbg(estado_dbg)
  );

  generador_transacciones_rtc #(.T_PULSO(1)) u_dut_p1 (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .escritura(escritura),
    .dir_base(dir_base), .longitud(longitud), .abortar(abortar),
    .dato_escribir(dato_escribir), .bus_dato_in(bus_dato_in),
    .a_d(p_a_d), .cs(p_cs), .wr(p_wr), .rd(p_rd), .bus_dato_out(p_bus_dato_out),
    .bus_oe(p_bus_oe), .indice(p_indice), .dato_leido(p_dato_leido),
    .dato_valido(p_dato_valido), .ocupado(p_ocupado), .listo(p_listo),
    .estado_dbg(p_estado_dbg)
  );

  // Expected {a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido} at cycle k
  // of a burst of nbytes bytes at the default 1/4/1 timing.
  function automatic logic [7:0] exp_sig(input int k, input int nbytes, input bit esc);
    int o;
    bit busy, ap, dp;
    busy = (k >= 1) && (k <= 12 * nbytes);
    o    = (k - 1) % 12 + 1;
    ap   = busy && (o >= 2) && (o <= 5);
    dp   = busy && (o >= 8) && (o <= 11);
    return {!(busy && o <= 6), !(ap || dp), !(ap || (dp && esc)), !(dp && !esc),
            busy && (esc || o <= 6), busy, (k == 12 * nbytes + 1),
            busy && !esc && (o == 12)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // Entered and left at 1 time unit after a rising edge.
  // inicio is high for cycles 0..inicio_hasta. abortar is high in cycle
  // abort_cyc. bus_dato_in carries a per-cycle pattern.
  // ---------------------------------------------------------------------------
  task automatic capture(input int n, input int abort_cyc, input int inicio_hasta);
    for (int k = 0; k < n; k++) begin
      inicio      = (k <= inicio_hasta);
      abortar     = (k == abort_cyc);
      bus_dato_in = 8'(k * 7 + 3);
      @(negedge clk);
      c_sig[k] = {a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido};
      c_out[k] = bus_dato_out;
      c_dl[k]  = dato_leido;
      c_idx[k] = indice;
      p_sig[k] = {p_a_d, p_cs, p_wr, p_rd, p_bus_oe, p_ocupado, p_listo, p_dato_valido};
      p_out[k] = p_bus_dato_out;
      p_dl[k]  = p_dato_leido;
      @(posedge clk);
      #1;
    end
    inicio  = 1'b0;
    abortar = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b1; inicio = 1'b0; escritura = 1'b0; dir_base = 8'h00;
    longitud = 5'd0; abortar = 1'b0; dato_escribir = 8'h00; bus_dato_in = 8'h00;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido} !== 8'b1111_0000) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 11110000",
               {a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido});
    end
    checks++;
    if (bus_dato_out !== 8'h00 || indice !== 5'd0 || dato_leido !== 8'h00) begin
      errors++;
      $display("FAIL reset_values bus_dato_out=%h indice=%0d dato_leido=%h expected 00 0 00",
               bus_dato_out, indice, dato_leido);
    end
    checks++;
    if ({p_a_d, p_cs, p_wr, p_rd, p_bus_oe, p_ocupado, p_listo, p_dato_valido} !== 8'b1111_0000) begin
      errors++;
      $display("FAIL reset_p1 got %b expected 11110000",
               {p_a_d, p_cs, p_wr, p_rd, p_bus_oe, p_ocupado, p_listo, p_dato_valido});
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    int nrd;
    int ndv;
    nrd = 0;
    ndv = 0;
    escritura = 1'b0; dir_base = 8'h21; longitud = 5'd3;
    capture(39, -1, 0);
    for (int k = 0; k < 39; k++) begin
      int o, b;
      o = (k - 1) % 12 + 1;
      b = (k - 1) / 12;
      checks++;
      if (c_sig[k] !== exp_sig(k, 3, 1'b0)) begin
        errors++;
        $display("FAIL read_sig cycle %0d got %b expected %b", k, c_sig[k], exp_sig(k, 3, 1'b0));
      end
      if (k >= 1 && k <= 36) begin
        checks++;
        if (c_idx[k] !== 5'(b)) begin
          errors++;
          $display("FAIL read_indice cycle %0d got %0d expected %0d", k, c_idx[k], b);
        end
        if (o <= 6) begin
          checks++;
          if (c_out[k] !== 8'(8'h21 + b)) begin
            errors++;
            $display("FAIL read_addr cycle %0d got %h expected %h", k, c_out[k], 8'(8'h21 + b));
          end
        end
        if (o == 12) begin
          checks++;
          if (c_dl[k] !== 8'((k - 1) * 7 + 3)) begin
            errors++;
            $display("FAIL read_data cycle %0d got %h expected %h", k, c_dl[k], 8'((k - 1) * 7 + 3));
          end
        end
      end
      if (c_sig[k][4] === 1'b0) nrd++;
      if (c_sig[k][0] === 1'b1) ndv++;
    end
    checks++;
    if (nrd != 12 || ndv != 3) begin
      errors++;
      $display("FAIL read_counts rd_low=%0d dato_valido=%0d expected 12 3", nrd, ndv);
    end
  endtask

  task automatic test_write();
    int nwr;
    nwr = 0;
    escritura = 1'b1; dir_base = 8'hFF; longitud = 5'd2; dato_escribir = 8'hA5;
    capture(27, -1, 0);
    for (int k = 0; k < 27; k++) begin
      int o, b;
      o = (k - 1) % 12 + 1;
      b = (k - 1) / 12;
      checks++;
      if (c_sig[k] !== exp_sig(k, 2, 1'b1)) begin
        errors++;
        $display("FAIL write_sig cycle %0d got %b expected %b", k, c_sig[k], exp_sig(k, 2, 1'b1));
      end
      if (k >= 1 && k <= 24) begin
        checks++;
        if (o <= 6 && c_out[k] !== 8'(8'hFF + b)) begin
          errors++;
          $display("FAIL write_addr cycle %0d got %h expected %h", k, c_out[k], 8'(8'hFF + b));
        end else if (o >= 7 && c_out[k] !== 8'hA5) begin
          errors++;
          $display("FAIL write_data cycle %0d got %h expected a5", k, c_out[k]);
        end
      end
      if (c_sig[k][5] === 1'b0) nwr++;
    end
    checks++;
    if (nwr != 16) begin
      errors++;
      $display("FAIL write_wr_low_count got %0d expected 16", nwr);
    end
  endtask

  task automatic test_longitud_cero();
    escritura = 1'b0; dir_base = 8'h05; longitud = 5'd0;
    capture(4, -1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_sig[k] !== exp_sig(k, 0, 1'b0)) begin
        errors++;
        $display("FAIL len0_sig cycle %0d got %b expected %b", k, c_sig[k], exp_sig(k, 0, 1'b0));
      end
    end
  endtask

  task automatic test_abort();
    int max_idx;
    max_idx = 0;
    escritura = 1'b0; dir_base = 8'h30; longitud = 5'd4;
    capture(28, 15, 0);
    for (int k = 0; k < 28; k++) begin
      checks++;
      if (c_sig[k] !== exp_sig(k, 2, 1'b0)) begin
        errors++;
        $display("FAIL abort_sig cycle %0d got %b expected %b", k, c_sig[k], exp_sig(k, 2, 1'b0));
      end
      if (int'(c_idx[k]) > max_idx) max_idx = int'(c_idx[k]);
    end
    checks++;
    if (max_idx != 1) begin
      errors++;
      $display("FAIL abort_indice_max got %0d expected 1", max_idx);
    end
  endtask

  task automatic test_clamp();
    escritura = 1'b1; dir_base = 8'hF8; longitud = 5'd31; dato_escribir = 8'h3C;
    capture(195, -1, 0);
    for (int k = 0; k < 195; k++) begin
      checks++;
      if (c_sig[k] !== exp_sig(k, 16, 1'b1)) begin
        errors++;
        $display("FAIL clamp_sig cycle %0d got %b expected %b", k, c_sig[k], exp_sig(k, 16, 1'b1));
      end
    end
    checks++;
    if (c_out[181] !== 8'h07 || c_idx[181] !== 5'd15) begin
      errors++;
      $display("FAIL clamp_last_byte addr=%h indice=%0d expected 07 15", c_out[181], c_idx[181]);
    end
  endtask

  task automatic test_reset_mid_burst();
    escritura = 1'b0; dir_base = 8'h40; longitud = 5'd2;
    capture(8, -1, 0);
    checks++;
    if (rd !== 1'b0 || cs !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre rd=%b cs=%b expected 0 0", rd, cs);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido} !== 8'b1111_0000 || indice !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_async got %b indice=%0d expected 11110000 0",
               {a_d, cs, wr, rd, bus_oe, ocupado, listo, dato_valido}, indice);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (listo !== 1'b0 || ocupado !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_hold listo=%b ocupado=%b expected 0 0", listo, ocupado);
      end
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    dir_base = 8'h50; longitud = 5'd1;
    capture(15, -1, 0);
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (c_sig[k] !== exp_sig(k, 1, 1'b0)) begin
        errors++;
        $display("FAIL rstmid_new_sig cycle %0d got %b expected %b", k, c_sig[k], exp_sig(k, 1, 1'b0));
      end
    end
    checks++;
    if (c_out[1] !== 8'h50 || c_idx[1] !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_new_start addr=%h indice=%0d expected 50 0", c_out[1], c_idx[1]);
    end
  endtask

  task automatic test_pulso_uno();
    logic [7:0] e;
    escritura = 1'b0; dir_base = 8'h10; longitud = 5'd2;
    capture(27, -1, 0);
    for (int k = 0; k < 16; k++) begin
      int o, b;
      bit busy;
      busy = (k >= 1) && (k <= 12);
      o    = (k - 1) % 6 + 1;
      b    = (k - 1) / 6;
      e    = {!(busy && o <= 3), !(busy && (o == 2 || o == 5)), !(busy && o == 2),
              !(busy && o == 5), busy && o <= 3, busy, (k == 13), busy && o == 6};
      checks++;
      if (p_sig[k] !== e) begin
        errors++;
        $display("FAIL p1_sig cycle %0d got %b expected %b", k, p_sig[k], e);
      end
      if (busy && o == 1) begin
        checks++;
        if (p_out[k] !== 8'(8'h10 + b)) begin
          errors++;
          $display("FAIL p1_addr cycle %0d got %h expected %h", k, p_out[k], 8'(8'h10 + b));
        end
      end
      if (busy && o == 6) begin
        checks++;
        if (p_dl[k] !== 8'((k - 1) * 7 + 3)) begin
          errors++;
          $display("FAIL p1_data cycle %0d got %h expected %h", k, p_dl[k], 8'((k - 1) * 7 + 3));
        end
      end
    end
  endtask

  task automatic test_inicio_sostenido();
    logic [7:0] e;
    int nlisto;
    nlisto = 0;
    escritura = 1'b0; dir_base = 8'h60; longitud = 5'd1;
    capture(29, -1, 27);
    for (int k = 0; k < 29; k++) begin
      e = (k < 14) ? exp_sig(k, 1, 1'b0) : exp_sig(k - 14, 1, 1'b0);
      checks++;
      if (c_sig[k] !== e) begin
        errors++;
        $display("FAIL hold_sig cycle %0d got %b expected %b", k, c_sig[k], e);
      end
      if (c_sig[k][1] === 1'b1) nlisto++;
    end
    checks++;
    if (nlisto != 2 || c_out[15] !== 8'h60 || c_idx[15] !== 5'd0) begin
      errors++;
      $display("FAIL hold_second_burst listo_count=%0d addr=%h indice=%0d expected 2 60 0",
               nlisto, c_out[15], c_idx[15]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_read();
    test_write();
    test_longitud_cero();
    test_abort();
    test_clamp();
    test_reset_mid_burst();
    test_pulso_uno();
    test_inicio_sostenido();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
